// File: rtl/mem_pkg.sv
// Shared definitions for the 16-bit external SRAM data path.
// State encoding, default address map base and SRAM data width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int          DATA_W        = 16;

endpackage

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses (low half first).
// ready drops while an access is in flight so the pipeline freezes.
//
// state | meaning
// IDLE  | waiting; ready follows absence of a request
// LOW   | low halfword access, held WAIT_CYCLES+1 cycles
// HIGH  | high halfword access, held WAIT_CYCLES+1 cycles
// DONE  | one-cycle completion pulse on ready
module sram_controller
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [DATA_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [DATA_W-1:0]  sram_dq_in
);

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  state_t             state, state_nx;
  logic [2:0]         cnt;
  logic               is_wr;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        wdata;
  logic [31:0]        off;
  logic               req;
  logic               last;
  logic               in_phase;
  logic               drive;
  logic               unused_off;

  assign req        = rd_en | wr_en;
  assign off        = address - BASE_ADDR;
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign last       = (cnt == 3'd0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = LOW;
      LOW:  if (last) state_nx = HIGH;
      HIGH: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pad drive is cut by rst directly so a reset mid-write releases DQ at once.
  always_comb begin
    in_phase    = (state == LOW) || (state == HIGH);
    drive       = is_wr && in_phase && !rst;
    ready       = (state == DONE) || ((state == IDLE) && !req);
    sram_we_n   = !drive;
    sram_dq_oe  = drive;
    sram_dq_out = '0;
    sram_addr   = '0;
    if (drive) sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
    if (state == LOW)  sram_addr = {word, 1'b0};
    if (state == HIGH) sram_addr = {word, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      readData <= 32'd0;
      is_wr    <= 1'b0;
      word     <= '0;
      wdata    <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            is_wr <= wr_en;
            word  <= off[SRAM_AW:2];
            wdata <= writeData;
            cnt   <= WAIT_LD;
          end
        end
        LOW, HIGH: begin
          if (last) begin
            cnt <= WAIT_LD;
            if (!is_wr) begin
              if (state == LOW) readData[15:0]  <= sram_dq_in;
              else              readData[31:16] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: two controllers (WAIT_CYCLES 1 and 0) each on an async SRAM model,
// checked against a word-level reference memory and the documented latency.
module tb_sram_controller;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        wr_en      [2];
  logic        rd_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [17:0] sram_addr  [2];
  logic        sram_we_n  [2];
  logic [15:0] dq_out     [2];
  logic [15:0] dq_in      [2];
  logic        dq_oe      [2];

  bit [15:0] mem0 [262144];
  bit [15:0] mem1 [262144];

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];

  sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(18), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .address(address[0]), .writeData(write_data[0]), .readData(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_we_n(sram_we_n[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0])
  );

  sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(18), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .address(address[1]), .writeData(write_data[1]), .readData(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_we_n(sram_we_n[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1])
  );

  // Asynchronous SRAM: read data follows the address within the cycle.
  always @(posedge clk) if (!sram_we_n[0]) mem0[sram_addr[0]] <= dq_out[0];
  always @(posedge clk) if (!sram_we_n[1]) mem1[sram_addr[1]] <= dq_out[1];
  assign dq_in[0] = sram_we_n[0] ? mem0[sram_addr[0]] : 16'h0000;
  assign dq_in[1] = sram_we_n[1] ? mem1[sram_addr[1]] : 16'h0000;

  function automatic int wait_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int word_of(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % 32'd131072);
  endfunction

  function automatic logic [15:0] peek(int k, int half_addr);
    return (k == 0) ? mem0[half_addr] : mem1[half_addr];
  endfunction

  function automatic logic [31:0] ref_get(int k, int w);
    int key;
    key = (k << 17) + w;
    return ref_mem.exists(key) ? ref_mem[key] : 32'd0;
  endfunction

  task automatic idle(int k, int n);
    wr_en[k] = 1'b0;
    rd_en[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transaction; chained means the caller sits in the DONE cycle of the previous one.
  task automatic run_access(int k, bit wr, bit rd, logic [31:0] addr, logic [31:0] data,
                            bit chained, bit scramble);
    int n, exp_lat, w;
    bit done;
    logic [31:0] exp;
    wr_en[k] = wr;
    rd_en[k] = rd;
    address[k] = addr;
    write_data[k] = data;
    if (chained) begin @(posedge clk); #1; end
    else #1;
    compared++;
    if (ready[k] !== 1'b0) begin
      mismatched++;
      $display("FAIL accept_ready k=%0d: got %b want 0", k, ready[k]);
    end
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (dq_oe[k] === 1'b1 && sram_we_n[k] === 1'b1) begin
        compared++; mismatched++;
        $display("FAIL oe_without_we k=%0d cycle %0d: oe=1 we_n=1", k, n);
      end
      if (ready[k] === 1'b1) done = 1;
      else if (scramble) begin
        address[k] = $urandom;
        write_data[k] = $urandom;
        wr_en[k] = 1'($urandom);
        rd_en[k] = 1'($urandom);
      end
    end
    exp_lat = 2 * (wait_of(k) + 1) + 1;
    compared++;
    if (n !== exp_lat) begin
      mismatched++;
      $display("FAIL latency k=%0d addr=%h: ready at cycle %0d want %0d", k, addr, n, exp_lat);
    end
    w = word_of(addr);
    if (wr) begin
      ref_mem[(k << 17) + w] = data;
      compared++;
      if ({peek(k, 2*w+1), peek(k, 2*w)} !== data) begin
        mismatched++;
        $display("FAIL sram_content k=%0d word %0d: got %h_%h want %h",
                 k, w, peek(k, 2*w+1), peek(k, 2*w), data);
      end
      compared++;
      if (read_data[k] !== last_rd[k]) begin
        mismatched++;
        $display("FAIL readdata_hold_on_write k=%0d: got %h want %h", k, read_data[k], last_rd[k]);
      end
    end else begin
      exp = ref_get(k, w);
      last_rd[k] = exp;
      compared++;
      if (read_data[k] !== exp) begin
        mismatched++;
        $display("FAIL read_data k=%0d addr=%h: got %h want %h", k, addr, read_data[k], exp);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
      address[k] = 32'd0; write_data[k] = 32'd0; last_rd[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({ready[k], sram_we_n[k], dq_oe[k]} !== 3'b110) begin
        mismatched++;
        $display("FAIL reset_ctrl k=%0d: ready/we_n/oe=%b%b%b want 110", k, ready[k], sram_we_n[k], dq_oe[k]);
      end
      compared++;
      if (read_data[k] !== 32'd0 || sram_addr[k] !== 18'd0 || dq_out[k] !== 16'd0) begin
        mismatched++;
        $display("FAIL reset_data k=%0d: rd=%h addr=%h dq=%h want all zero", k, read_data[k], sram_addr[k], dq_out[k]);
      end
      rst[k] = 1'b0;
    end
    idle(0, 1);
    compared++;
    if (ready[0] !== 1'b1 || sram_we_n[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_ready: ready=%b we_n=%b want 1 1", ready[0], sram_we_n[0]);
    end
  endtask

  task automatic test_write_read();
    run_access(0, 1, 0, 32'd1028, 32'hDEADBEEF, 0, 0);
    compared++;
    if (mem0[2] !== 16'hBEEF || mem0[3] !== 16'hDEAD) begin
      mismatched++;
      $display("FAIL halves_1028: addr2=%h addr3=%h want beef dead", mem0[2], mem0[3]);
    end
    idle(0, 1);
    run_access(0, 0, 1, 32'd1028, 32'h0, 0, 0);
    idle(0, 4);
    compared++;
    if (read_data[0] !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL read_hold: got %h want deadbeef", read_data[0]);
    end
    run_access(0, 0, 1, 32'd1030, 32'h0, 0, 0);
    idle(0, 1);
  endtask

  task automatic test_wrap();
    run_access(0, 1, 0, BASE + 32'd4 * 32'd131072, 32'hCAFEF00D, 0, 0);
    compared++;
    if (mem0[0] !== 16'hF00D || mem0[1] !== 16'hCAFE) begin
      mismatched++;
      $display("FAIL wrap_halves: addr0=%h addr1=%h want f00d cafe", mem0[0], mem0[1]);
    end
    idle(0, 1);
    run_access(0, 0, 1, BASE, 32'h0, 0, 0);
    idle(0, 1);
    run_access(0, 0, 1, BASE - 32'd4, 32'h0, 0, 0);
    idle(0, 1);
  endtask

  task automatic test_reset_mid();
    run_access(0, 1, 0, 32'd1040, 32'h55559999, 0, 0);
    idle(0, 1);
    wr_en[0] = 1'b1; address[0] = 32'd1040; write_data[0] = 32'hAAAA1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1; wr_en[0] = 1'b0;
    #1;
    compared++;
    if (sram_we_n[0] !== 1'b1 || dq_oe[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: we_n=%b oe=%b want 1 0", sram_we_n[0], dq_oe[0]);
    end
    @(posedge clk); #1;
    compared++;
    if (ready[0] !== 1'b1 || sram_we_n[0] !== 1'b1 || read_data[0] !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_mid_state: ready=%b we_n=%b rd=%h want 1 1 0", ready[0], sram_we_n[0], read_data[0]);
    end
    rst[0] = 1'b0;
    last_rd[0] = 32'd0;
    compared++;
    if (mem0[8] !== 16'h1111 || mem0[9] !== 16'h5555) begin
      mismatched++;
      $display("FAIL partial_write: addr8=%h addr9=%h want 1111 5555", mem0[8], mem0[9]);
    end
    ref_mem[4] = 32'h55551111;
    idle(0, 1);
    run_access(0, 0, 1, 32'd1040, 32'h0, 0, 0);
    idle(0, 1);
  endtask

  task automatic test_back_to_back();
    run_access(1, 1, 0, 32'd1032, 32'h12345678, 0, 0);
    run_access(1, 0, 1, 32'd1032, 32'h0, 1, 0);
    run_access(1, 1, 1, 32'd1036, 32'h0BADCAFE, 1, 0);
    compared++;
    if (mem1[6] !== 16'hCAFE || mem1[7] !== 16'h0BAD) begin
      mismatched++;
      $display("FAIL both_high_is_write: addr6=%h addr7=%h want cafe 0bad", mem1[6], mem1[7]);
    end
    run_access(1, 0, 1, 32'd1036, 32'h0, 1, 0);
    idle(1, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit w, chain;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        w = 1'($urandom);
        chain = (i > 0) && ($urandom_range(0, 1) == 1);
        if (i > 0 && !chain) idle(k, $urandom_range(1, 3));
        run_access(k, w, !w || ($urandom_range(0, 3) == 0), a, $urandom, chain, 1);
      end
      idle(k, 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
